// File: rtl/wm_pkg.sv
// wm_pkg: constants and helpers shared by the watermark insertion and
// extraction paths.
package wm_pkg;

    localparam int PIX_W  = 8;
    localparam int DIFF_W = 9;

    localparam logic [1:0] WM_SYM_NONE = 2'b00;
    localparam logic [1:0] WM_SYM_A    = 2'b01;
    localparam logic [1:0] WM_SYM_B    = 2'b10;

    // Residual classification: a positive excursion beyond th is symbol A,
    // a negative one is symbol B, anything inside the band is unmarked.
    function automatic logic [1:0] wm_classify(input logic [DIFF_W-1:0] diff, input int th);
        int d;
        d = {{(32-DIFF_W){diff[DIFF_W-1]}}, diff};
        if (d > th) begin
            return WM_SYM_A;
        end else if (d < -th) begin
            return WM_SYM_B;
        end
        return WM_SYM_NONE;
    endfunction

endpackage

// File: rtl/wm_predict.sv
// wm_predict: two-stage centre-pixel predictor. Stage 1 sums neighbours 2
// and 4; stage 2 averages that with neighbour 3 (truncating at each step).
// Both stages hold while en is low.
module wm_predict
    import wm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [PIX_W-1:0] pix_c,
    input  logic [PIX_W-1:0] pix_n2,
    input  logic [PIX_W-1:0] pix_n3,
    input  logic [PIX_W-1:0] pix_n4,
    output logic             out_valid,
    output logic             out_last,
    output logic [PIX_W-1:0] out_pix_c,
    output logic [PIX_W-1:0] out_pred
);

    logic             v1_q, v1_d;
    logic             last1_q, last1_d;
    logic [PIX_W:0]   sum_q, sum_d;
    logic [PIX_W-1:0] c1_q, c1_d;
    logic [PIX_W-1:0] n3_q, n3_d;
    logic             v2_q, v2_d;
    logic             last2_q, last2_d;
    logic [PIX_W-1:0] c2_q, c2_d;
    logic [PIX_W-1:0] pred_q, pred_d;
    logic [PIX_W-1:0] avg;
    logic [PIX_W:0]   pred_sum;

    // Next-state for both stages; data only moves with a valid token.
    always_comb begin
        v1_d    = v1_q;
        last1_d = last1_q;
        sum_d   = sum_q;
        c1_d    = c1_q;
        n3_d    = n3_q;
        v2_d    = v2_q;
        last2_d = last2_q;
        c2_d    = c2_q;
        pred_d  = pred_q;
        avg      = PIX_W'(sum_q >> 1);
        pred_sum = {1'b0, n3_q} + {1'b0, avg};
        if (en) begin
            v1_d = in_valid;
            if (in_valid) begin
                sum_d   = {1'b0, pix_n2} + {1'b0, pix_n4};
                c1_d    = pix_c;
                n3_d    = pix_n3;
                last1_d = in_last;
            end
            v2_d = v1_q;
            if (v1_q) begin
                pred_d  = PIX_W'(pred_sum >> 1);
                c2_d    = c1_q;
                last2_d = last1_q;
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            sum_q   <= '0;
            c1_q    <= '0;
            n3_q    <= '0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            c2_q    <= '0;
            pred_q  <= '0;
        end else begin
            v1_q    <= v1_d;
            last1_q <= last1_d;
            sum_q   <= sum_d;
            c1_q    <= c1_d;
            n3_q    <= n3_d;
            v2_q    <= v2_d;
            last2_q <= last2_d;
            c2_q    <= c2_d;
            pred_q  <= pred_d;
        end
    end

    assign out_valid = v2_q;
    assign out_last  = last2_q;
    assign out_pix_c = c2_q;
    assign out_pred  = pred_q;

endmodule

// File: rtl/wm_extractor.sv
// wm_extractor: blind watermark extraction. Predicts each centre pixel from
// its neighbours, classifies the residual into a 2-bit symbol and packs four
// symbols per output byte (symbol 0 in bits [1:0]).
// Optional WM_EXTRACT_STATS_EN adds saturating stat_mark/stat_total counters.
module wm_extractor
    import wm_pkg::*;
#(
    parameter int TH           = 8,
    parameter int SYM_PER_BYTE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [PIX_W-1:0] pix_c,
    input  logic [PIX_W-1:0] pix_n2,
    input  logic [PIX_W-1:0] pix_n3,
    input  logic [PIX_W-1:0] pix_n4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic [2:0]       out_count,
    output logic             out_last
`ifdef WM_EXTRACT_STATS_EN
    ,
    output logic [15:0]      stat_mark,
    output logic [15:0]      stat_total
`endif
);

    if (SYM_PER_BYTE != 4) begin : g_bad_cfg
        $error("wm_extractor: SYM_PER_BYTE must be 4");
    end

    logic             stall, adv, hs;
    logic             s2_valid, s2_last;
    logic [PIX_W-1:0] s2_pix_c, s2_pred;
    logic [DIFF_W-1:0] diff;
    logic [1:0]       sym;
    logic [7:0]       merged;

    logic             rdy_q, rdy_d;
    logic             v3_q, v3_d;
    logic [1:0]       sym3_q, sym3_d;
    logic             last3_q, last3_d;
    logic [1:0]       idx_q, idx_d;
    logic [5:0]       pack_q, pack_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic [2:0]       out_count_q, out_count_d;
    logic             out_last_q, out_last_d;

    assign stall    = out_valid_q & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = rdy_q & ~stall;
    assign hs       = in_valid & in_ready;

    wm_predict u_predict (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (adv),
        .in_valid  (hs),
        .in_last   (in_last),
        .pix_c     (pix_c),
        .pix_n2    (pix_n2),
        .pix_n3    (pix_n3),
        .pix_n4    (pix_n4),
        .out_valid (s2_valid),
        .out_last  (s2_last),
        .out_pix_c (s2_pix_c),
        .out_pred  (s2_pred)
    );

    // S3: residual and classification.
    always_comb begin
        diff    = {1'b0, s2_pix_c} - {1'b0, s2_pred};
        sym     = wm_classify(diff, TH);
        v3_d    = v3_q;
        sym3_d  = sym3_q;
        last3_d = last3_q;
        if (adv) begin
            v3_d = s2_valid;
            if (s2_valid) begin
                sym3_d  = sym;
                last3_d = s2_last;
            end
        end
    end

    // Packer: accumulate into slot idx, flush on the fourth symbol or on last.
    // Retiring the held byte and loading a new one can share one edge.
    always_comb begin
        rdy_d       = 1'b1;
        idx_d       = idx_q;
        pack_d      = pack_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        merged      = {2'b00, pack_q} | ({6'b0, sym3_q} << {idx_q, 1'b0});
        if (adv) begin
            if (out_valid_q) begin
                out_valid_d = 1'b0;
            end
            if (v3_q) begin
                if (idx_q == 2'd3 || last3_q) begin
                    out_valid_d = 1'b1;
                    out_byte_d  = merged;
                    out_count_d = {1'b0, idx_q} + 3'd1;
                    out_last_d  = last3_q;
                    idx_d       = '0;
                    pack_d      = '0;
                end else begin
                    pack_d = merged[5:0];
                    idx_d  = idx_q + 2'd1;
                end
            end
        end
    end

    // S3 and packer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q       <= 1'b0;
            v3_q        <= 1'b0;
            sym3_q      <= '0;
            last3_q     <= 1'b0;
            idx_q       <= '0;
            pack_q      <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            rdy_q       <= rdy_d;
            v3_q        <= v3_d;
            sym3_q      <= sym3_d;
            last3_q     <= last3_d;
            idx_q       <= idx_d;
            pack_q      <= pack_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign out_count = out_count_q;
    assign out_last  = out_last_q;

`ifdef WM_EXTRACT_STATS_EN
    logic [15:0] mark_q, mark_d;
    logic [15:0] total_q, total_d;

    // Saturating symbol statistics; restart from zero once a frame retires.
    always_comb begin
        mark_d  = mark_q;
        total_d = total_q;
        if (out_valid_q & out_ready & out_last_q) begin
            mark_d  = '0;
            total_d = '0;
        end
        if (adv & v3_q) begin
            if (total_d != '1) begin
                total_d = total_d + 16'd1;
            end
            if (sym3_q != WM_SYM_NONE && mark_d != '1) begin
                mark_d = mark_d + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mark_q  <= '0;
            total_q <= '0;
        end else begin
            mark_q  <= mark_d;
            total_q <= total_d;
        end
    end

    assign stat_mark  = mark_q;
    assign stat_total = total_q;
`endif

endmodule

// File: tb/tb_wm_extractor.sv
// tb_wm_extractor: directed and randomized checks of wm_extractor against an
// arithmetic reference model of prediction, classification and packing.
module tb_wm_extractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;
    logic [7:0] pix_c, pix_n2, pix_n3, pix_n4;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic [2:0] out_count;
    logic       out_last;

    int errors = 0;
    int checks = 0;

    // Entries are {last, count, byte}.
    logic [11:0] got_q[$];
    logic [11:0] exp_q[$];
    int          part_q[$];

    wm_extractor #(.TH(8), .SYM_PER_BYTE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .pix_c     (pix_c),
        .pix_n2    (pix_n2),
        .pix_n3    (pix_n3),
        .pix_n4    (pix_n4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_count (out_count),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Record every retired byte.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
            got_q.push_back({out_last, out_count, out_byte});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ref_pred(int n2, int n3, int n4);
        return (n3 + (n2 + n4) / 2) / 2;
    endfunction

    function automatic int ref_sym(int c, int n2, int n3, int n4);
        int d;
        d = c - ref_pred(n2, n3, n4);
        if (d > 8) return 1;
        if (d < -8) return 2;
        return 0;
    endfunction

    task automatic model_add(int s, bit last);
        int b;
        part_q.push_back(s);
        if (part_q.size() == 4 || last) begin
            b = 0;
            for (int i = 0; i < part_q.size(); i++) b += part_q[i] * (4 ** i);
            exp_q.push_back({last, 3'(part_q.size()), 8'(b)});
            part_q.delete();
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one quad from posedge+1 and hold it until accepted.
    task automatic send(int c, int n2, int n3, int n4, bit last);
        int n;
        pix_c = 8'(c); pix_n2 = 8'(n2); pix_n3 = 8'(n3); pix_n4 = 8'(n4);
        in_last = last;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b required 1 within 300 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_got(int n, output bit ok);
        int k;
        k = 0;
        while (got_q.size() < n && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        pix_c = '0; pix_n2 = '0; pix_n3 = '0; pix_n4 = '0;
        idle(3);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++;
        if (out_byte !== 8'h00) begin errors++; $display("FAIL rst_out_byte: got %h required 00", out_byte); end
        checks++;
        if (out_count !== 3'd0) begin errors++; $display("FAIL rst_out_count: got %0d required 0", out_count); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b required 0", out_last); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rel_in_ready_low: got %b required 0", in_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready_high: got %b required 1", in_ready); end
    endtask

    task automatic test_neutral;
        got_q.delete();
        for (int i = 0; i < 4; i++) send(100, 100, 100, 100, 1'b0);
        idle(2);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL neutral_latency_early: out_valid=%b required 0", out_valid); end
        idle(1);
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'h00 || out_count !== 3'd4 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL neutral_out: valid=%b byte=%h cnt=%0d last=%b required 1/00/4/0",
                     out_valid, out_byte, out_count, out_last);
        end
        idle(4);
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL neutral_count: got %0d bytes required 1", got_q.size()); end
    endtask

    task automatic test_mixed;
        bit ok;
        got_q.delete();
        send(120, 100, 100, 100, 1'b0);
        send(80, 100, 100, 100, 1'b0);
        send(100, 100, 100, 100, 1'b0);
        send(120, 100, 100, 100, 1'b0);
        wait_got(1, ok);
        checks++;
        if (!ok || got_q[0] !== {1'b0, 3'd4, 8'h49}) begin
            errors++;
            $display("FAIL mixed: got %h required %h (ok=%b)", ok ? got_q[0] : 12'hxxx, {1'b0, 3'd4, 8'h49}, ok);
        end
    endtask

    task automatic test_rounding;
        bit ok;
        got_q.delete();
        send(254, 255, 255, 254, 1'b1);
        send(108, 100, 100, 100, 1'b0);
        send(109, 100, 100, 100, 1'b0);
        send(92, 100, 100, 100, 1'b0);
        send(91, 100, 100, 100, 1'b0);
        wait_got(2, ok);
        checks++;
        if (!ok || got_q[0] !== {1'b1, 3'd1, 8'h00}) begin
            errors++;
            $display("FAIL rounding_trunc: got %h required %h (ok=%b)", ok ? got_q[0] : 12'hxxx, {1'b1, 3'd1, 8'h00}, ok);
        end
        checks++;
        if (!ok || got_q[1] !== {1'b0, 3'd4, 8'h84}) begin
            errors++;
            $display("FAIL rounding_th: got %h required %h (ok=%b)", ok ? got_q[1] : 12'hxxx, {1'b0, 3'd4, 8'h84}, ok);
        end
    endtask

    task automatic test_partial;
        bit ok;
        got_q.delete();
        send(120, 100, 100, 100, 1'b0);
        send(80, 100, 100, 100, 1'b1);
        wait_got(1, ok);
        checks++;
        if (!ok || got_q[0] !== {1'b1, 3'd2, 8'h09}) begin
            errors++;
            $display("FAIL partial: got %h required %h (ok=%b)", ok ? got_q[0] : 12'hxxx, {1'b1, 3'd2, 8'h09}, ok);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        got_q.delete();
        out_ready = 1'b0;
        send(120, 100, 100, 100, 1'b0);
        send(80, 100, 100, 100, 1'b0);
        send(100, 100, 100, 100, 1'b0);
        send(120, 100, 100, 100, 1'b0);
        send(91, 100, 100, 100, 1'b0);
        send(109, 100, 100, 100, 1'b0);
        idle(1);
        pix_c = 8'd91; pix_n2 = 8'd100; pix_n3 = 8'd100; pix_n4 = 8'd100;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b required 0", i, in_ready); end
            checks++;
            if (out_valid !== 1'b1 || out_byte !== 8'h49) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b byte=%h required 1/49", i, out_valid, out_byte);
            end
            idle(1);
        end
        out_ready = 1'b1;
        send(91, 100, 100, 100, 1'b0);
        send(109, 100, 100, 100, 1'b0);
        wait_got(2, ok);
        idle(4);
        checks++;
        if (got_q.size() != 2) begin errors++; $display("FAIL bp_count: got %0d bytes required 2", got_q.size()); end
        checks++;
        if (!ok || got_q[0] !== {1'b0, 3'd4, 8'h49}) begin
            errors++;
            $display("FAIL bp_first: got %h required %h", ok ? got_q[0] : 12'hxxx, {1'b0, 3'd4, 8'h49});
        end
        checks++;
        if (!ok || got_q[1] !== {1'b0, 3'd4, 8'h66}) begin
            errors++;
            $display("FAIL bp_second: got %h required %h", ok ? got_q[1] : 12'hxxx, {1'b0, 3'd4, 8'h66});
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        got_q.delete();
        out_ready = 1'b0;
        send(120, 100, 100, 100, 1'b0);
        send(80, 100, 100, 100, 1'b0);
        send(100, 100, 100, 100, 1'b0);
        send(120, 100, 100, 100, 1'b0);
        send(120, 100, 100, 100, 1'b0);
        send(80, 100, 100, 100, 1'b0);
        idle(1);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre: out_valid=%b required 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: out_valid=%b in_ready=%b required 0/0", out_valid, in_ready);
        end
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);
        send(100, 100, 100, 100, 1'b0);
        send(100, 100, 100, 100, 1'b0);
        send(100, 100, 100, 100, 1'b0);
        send(120, 100, 100, 100, 1'b0);
        wait_got(1, ok);
        idle(6);
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL rmid_count: got %0d bytes required 1", got_q.size()); end
        checks++;
        if (!ok || got_q[0] !== {1'b0, 3'd4, 8'h40}) begin
            errors++;
            $display("FAIL rmid_byte: got %h required %h", ok ? got_q[0] : 12'hxxx, {1'b0, 3'd4, 8'h40});
        end
    endtask

    task automatic test_random;
        bit ok;
        bit done;
        got_q.delete();
        exp_q.delete();
        part_q.delete();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    int n2, n3, n4, c;
                    bit last;
                    n2 = $urandom_range(0, 255);
                    n3 = $urandom_range(0, 255);
                    n4 = $urandom_range(0, 255);
                    c  = ref_pred(n2, n3, n4) + $urandom_range(0, 40) - 20;
                    if (c < 0) c = 0;
                    if (c > 255) c = 255;
                    last = (i == 119) || ($urandom_range(0, 7) == 0);
                    send(c, n2, n3, n4, last);
                    model_add(ref_sym(c, n2, n3, n4), last);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_got(exp_q.size(), ok);
        idle(4);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_byte[%0d]: got last/cnt/byte=%h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_neutral;
        test_mixed;
        test_rounding;
        test_partial;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wm_extractor.md
Name: wm_extractor

Overview:
- Blind watermark extraction block. Recovers the 2-bit watermark symbols embedded by the insertion path.
- Consumes a stream of watermarked centre pixels, each with three neighbour pixels. Predicts the unmarked centre from the neighbours, classifies the residual into a symbol, and packs 4 symbols per output byte.
- Sits between the image read-back buffer and the watermark verification/UART path. Uses valid/ready handshakes on both sides.

Parameters:
- TH, 8: residual magnitude threshold; |diff| <= TH decodes as "no mark".
- SYM_PER_BYTE, 4: symbols packed per output word. Fixed at 4; any other value is illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input quad valid.
- in_ready  out  1  block can accept a quad this cycle.
- in_last  in  1  final pixel of frame; flushes a partial byte.
- pix_c  in  8  watermarked centre pixel.
- pix_n2  in  8  neighbour 2.
- pix_n3  in  8  neighbour 3.
- pix_n4  in  8  neighbour 4.
- out_valid  out  1  packed byte valid.
- out_ready  in  1  downstream accepts byte.
- out_byte  out  8  packed symbols; symbol 0 in [1:0], symbol 3 in [7:6].
- out_count  out  3  number of valid symbols in out_byte (1..4).
- out_last  out  1  byte carries the final symbol of the frame.

Behaviour:
- Reset (async, rst_n=0): all pipeline valids=0, out_valid=0, out_byte=0, out_count=0, out_last=0, packer index=0, in_ready=0. in_ready rises the first cycle after reset is released.
- Stall rule:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - All stages advance only when ~stall. A handshake occurs when in_valid & in_ready.
- Pipeline (3 stages plus packer register):
  - S1: register sum24 = pix_n2 + pix_n4 (9-bit); carry pix_c, pix_n3 and last.
  - S2: avg24 = sum24[8:1]; pred = (pix_n3 + avg24)[8:1], truncating, 8-bit; register pred and pix_c.
  - S3: diff = {1'b0,pix_c} - {1'b0,pred}, 9-bit signed, range -255..255. Classify: diff > TH gives sym=01; diff < -TH gives sym=10; otherwise sym=00. Symbol 11 is never produced.
  - Packer: shifts sym into slot [idx] and increments idx (2-bit).
- Packer flush: when idx==3, or the symbol carries last, load out_byte/out_count/out_last and set out_valid in the same edge.
  - Unused slots are zero. idx returns to 0.
  - out_count = idx+1. out_last = carried last.
- Latency: out_valid asserts 4 cycles after the handshake of the pixel that completes the byte (no stall).
- Throughput: 1 quad per cycle while out_ready=1.
- out_valid stays high with out_byte/out_count/out_last stable until out_valid & out_ready.
- Simultaneous flush and accept: if out_ready=1 on the cycle a new byte completes, the old byte retires and the new one loads in the same edge, with no bubble.
- Pipeline bubbles (in_valid=0) propagate as invalid stages. The packer does not advance on invalid stages.
- in_last with idx==3 behaves identically to a normal full flush, with out_last=1.
- Reset mid-frame discards any partial byte and in-flight quads. Nothing is emitted.

Optional Feature:
- Macro WM_EXTRACT_STATS_EN.
- Defined:
  - Adds outputs stat_mark [15:0] (count of symbols 01 or 10) and stat_total [15:0] (symbols decoded).
  - Both counters saturate at 16'hFFFF and clear on reset and on the cycle after an out_last byte retires.
- Undefined: ports and counters are absent. Core behaviour is unchanged.

Decomposition:
- Shared package wm_pkg:
  - symbol constants WM_SYM_NONE=2'b00, WM_SYM_A=2'b01, WM_SYM_B=2'b10.
  - pixel width constant PIX_W=8.
  - residual width DIFF_W=9.
  - The insertion path uses the same package.
- One sub-module: wm_predict. It holds stages S1–S2 (neighbour averaging, two registers, stall enable input) and outputs pred with valid.
- Classification and packing remain in wm_extractor.

Test Plan:
- Neutral pixel: n2=n3=n4=100, c=100, then three more identical quads. Required: out_byte=8'h00, out_count=4, out_last=0, 4 cycles after the 4th handshake.
- Mixed symbols: neighbours all 100; c = 120, 80, 100, 120. Required: symbols 01, 10, 00, 01, so out_byte=8'h49, out_count=4.
- Rounding/truncation: n2=255, n4=254, n3=255, c=254. Required: pred=254, diff=0, sym=00. Also c=108 vs pred 100 gives 00 (boundary TH); c=109 gives 01.
- Partial flush: 2 quads (c=120, 80, neighbours 100) with in_last on the 2nd. Required: out_byte=8'h09, out_count=2, out_last=1.
- Backpressure: out_ready=0 for 5 cycles while completing a byte. Required: in_ready=0 during the stall, out_byte held stable, no symbols lost, and the next byte is correct after release.
- Reset mid-operation: assert rst_n=0 after 2 quads. Required: out_valid=0 immediately. A subsequent 4-quad frame produces only its own byte with idx starting at 0.
